tlb: RTL and testbench
======================

Name: tlb

Overview:
- Fully-associative L1 TLB that translates 32-bit virtual addresses to physical addresses for the core's memory pipeline.
- Sits directly upstream of the ptw block.
- On a miss it issues one walk request on the ptw request channel, consumes the returned leaf PTE, refills an entry and answers the requester.
- PTE format: bits[31:12] = physical frame, bit0 V, bit1 R, bit2 W, bit3 X. A PTE of 0x00000000 means invalid.

Parameters:
ENTRIES, 8, number of TLB entries; power of two, >=2
IDX_W, $clog2(ENTRIES), entry index width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
req_valid_i  in  1  translation request valid
req_ready_o  out  1  TLB can accept a request
req_vaddr_i  in  32  virtual address
req_acc_i  in  2  access type: 0 read, 1 write, 2 execute, 3 reserved (treated as read)
resp_valid_o  out  1  translation result valid
resp_ready_i  in  1  requester accepts result
resp_paddr_o  out  32  physical address
resp_fault_o  out  1  page/permission fault
resp_hit_o  out  1  result came from TLB without a walk
flush_i  in  1  invalidate all entries (one-cycle pulse or level)
ptw_req_valid_o  out  1  walk request valid
ptw_req_ready_i  in  1  ptw accepts walk request
ptw_vaddr_o  out  32  vaddr to walk
ptw_resp_valid_i  in  1  ptw leaf PTE valid
ptw_resp_ready_o  out  1  TLB accepts PTE
ptw_pte_i  in  32  leaf PTE from ptw

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all entry valid bits cleared; replacement pointer=0; flush_pend=0.
  - All valid/ready outputs 0 except req_ready_o, which asserts once rst=1 and the FSM is in IDLE.
  - resp_paddr_o, resp_fault_o, resp_hit_o and ptw_vaddr_o reset to 0.
  - Reset mid-walk abandons the walk with no response.
- Entry contents: valid, vpn[31:12], ppn[31:12], flags[3:0].
- IDLE:
  - req_ready_o = ~flush_i.
  - flush_i in IDLE clears all valid bits on that edge; it takes priority over acceptance.
  - On req_valid_i&req_ready_o, latch vaddr and acc, then go to LOOKUP.
- LOOKUP (1 cycle): compare latched vaddr[31:12] against all valid entries.
  - Hit: go to RESP with resp_hit_o=1.
  - Miss: go to PTW_REQ.
  - At most one entry may match, guaranteed by refill.
- PTW_REQ:
  - ptw_req_valid_o=1 and ptw_vaddr_o=latched vaddr, held stable until ptw_req_ready_i.
  - On handshake, go to PTW_WAIT.
- PTW_WAIT:
  - ptw_resp_ready_o=1.
  - On ptw_resp_valid_i, capture the PTE.
  - If V=1 and flush_pend=0, refill: target the lowest-index invalid entry; otherwise target the entry at the replacement pointer, then increment the pointer (wraps ENTRIES-1 -> 0).
  - A PTE with V=0 is never installed.
  - Go to RESP with resp_hit_o=0.
- RESP:
  - resp_valid_o=1 with paddr/fault/hit held stable until resp_ready_i; go to IDLE on handshake.
  - flush_pend clears on entering IDLE.
- Fault rule, applied to hit or walked PTE:
  - V=0 -> fault.
  - acc=0 or 3 needs R; acc=1 needs W; acc=2 needs X.
  - On fault: resp_fault_o=1, resp_paddr_o=0.
  - A permission-faulting V=1 PTE is still installed.
- No fault: resp_paddr_o = {ppn, vaddr[11:0]}.
- flush_i outside IDLE:
  - Entry valid bits are cleared on that edge.
  - flush_pend is set if the FSM is in PTW_REQ or PTW_WAIT, so that the in-flight PTE is returned but not installed.
  - Flush during RESP does not alter the held response.
- Latency:
  - Hit: request accepted at edge E, resp_valid_o high after edge E+1.
  - Miss: ptw_req_valid_o high after edge E+1; resp_valid_o high the edge after the ptw response handshake.
- Only one outstanding request; req_ready_o=0 outside IDLE.

Test Plan:
- Reset, then read 0x00001234 with PTW model returning 0x1100000F:
  - exactly one ptw request with vaddr 0x00001234;
  - response paddr=0x11000234, fault=0, hit=0.
  - Repeat the read: paddr=0x11000234, hit=1, no ptw_req_valid_o, resp 2 cycles after valid.
- Read 0x80000000 with PTW returning 0x00000000: fault=1, paddr=0. A second access walks again (not installed).
- Execute 0x00002010 with PTW returning 0x12000007: fault=1 (X=0). A second execute hits (hit=1, fault=1, no walk); a write to 0x00002010 hits with paddr=0x12000010, fault=0.
- Fill 8 distinct pages 0x00000000..0x00007000, then access 0x00008000: evicts entry 0 (page 0x00000). Page 0x00000 then walks again; page 0x00001000 still hits.
- Assert flush_i while in PTW_WAIT for 0x00000000 (PTE 0x1000000F): response paddr=0x10000000, fault=0. The next access to 0x00000000 walks; prior cached pages also miss.
- Hold ptw_req_ready_i=0 for 5 cycles and resp_ready_i=0 for 3 cycles: valid and data stay stable throughout.
- Pull rst low mid-walk: all outputs return to reset values immediately and the subsequent access misses.

Source files
------------

// File: rtl/tlb.sv
// Fully-associative L1 TLB with a single outstanding translation. Misses are walked
// through the ptw channels and refilled lowest-free-first, otherwise round-robin.
module tlb #(
  parameter  int ENTRIES = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_vaddr_i,
  input  logic [1:0]  req_acc_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_paddr_o,
  output logic        resp_fault_o,
  output logic        resp_hit_o,
  input  logic        flush_i,
  output logic        ptw_req_valid_o,
  input  logic        ptw_req_ready_i,
  output logic [31:0] ptw_vaddr_o,
  input  logic        ptw_resp_valid_i,
  output logic        ptw_resp_ready_o,
  input  logic [31:0] ptw_pte_i
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_PTW_REQ, S_PTW_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        vaddr_q, vaddr_d;
  logic [1:0]         acc_q, acc_d;
  logic               flush_pend_q, flush_pend_d;
  logic [IDX_W-1:0]   rpl_ptr_q, rpl_ptr_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [31:0]        resp_paddr_q, resp_paddr_d;
  logic               resp_fault_q, resp_fault_d;
  logic               resp_hit_q, resp_hit_d;
  logic [31:0]        ptw_vaddr_q, ptw_vaddr_d;

  logic [19:0] vpn_q   [ENTRIES];
  logic [19:0] ppn_q   [ENTRIES];
  logic [3:0]  flags_q [ENTRIES];

  logic             hit;
  logic [19:0]      hit_ppn;
  logic [3:0]       hit_flags;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             fill_en;
  logic [IDX_W-1:0] fill_idx;
  logic             hit_fault, pte_fault;
  logic             unused_pte_bits;

  // Reserved access type 3 is checked as a read.
  function automatic logic perm_fault(input logic [3:0] flags, input logic [1:0] acc);
    logic allowed;
    case (acc)
      2'd1:    allowed = flags[2];
      2'd2:    allowed = flags[3];
      default: allowed = flags[1];
    endcase
    return !flags[0] || !allowed;
  endfunction

  assign hit_fault       = perm_fault(hit_flags, acc_q);
  assign pte_fault       = perm_fault(ptw_pte_i[3:0], acc_q);
  assign unused_pte_bits = ^ptw_pte_i[11:4];

  // Refill guarantees at most one match, so OR-combining the matching payloads is exact.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    hit       = 1'b0;
    hit_ppn   = '0;
    hit_flags = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && vpn_q[i] == vaddr_q[31:12]) begin
        hit       = 1'b1;
        hit_ppn   = hit_ppn | ppn_q[i];
        hit_flags = hit_flags | flags_q[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    vaddr_d      = vaddr_q;
    acc_d        = acc_q;
    flush_pend_d = flush_pend_q;
    rpl_ptr_d    = rpl_ptr_q;
    valid_d      = valid_q;
    resp_paddr_d = resp_paddr_q;
    resp_fault_d = resp_fault_q;
    resp_hit_d   = resp_hit_q;
    ptw_vaddr_d  = ptw_vaddr_q;
    fill_en      = 1'b0;
    fill_idx     = rpl_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          vaddr_d = req_vaddr_i;
          acc_d   = req_acc_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          resp_hit_d   = 1'b1;
          resp_fault_d = hit_fault;
          resp_paddr_d = hit_fault ? 32'h0 : {hit_ppn, vaddr_q[11:0]};
          state_d      = S_RESP;
        end else begin
          ptw_vaddr_d = vaddr_q;
          state_d     = S_PTW_REQ;
        end
      end
      S_PTW_REQ: begin
        if (ptw_req_ready_i) state_d = S_PTW_WAIT;
      end
      S_PTW_WAIT: begin
        if (ptw_resp_valid_i) begin
          resp_hit_d   = 1'b0;
          resp_fault_d = pte_fault;
          resp_paddr_d = pte_fault ? 32'h0 : {ptw_pte_i[31:12], vaddr_q[11:0]};
          state_d      = S_RESP;
          // A flush landing on the same edge as the PTE also suppresses the install.
          if (ptw_pte_i[0] && !flush_pend_q && !flush_i) begin
            fill_en = 1'b1;
            if (free_found) begin
              fill_idx = free_idx;
            end else begin
              fill_idx  = rpl_ptr_q;
              rpl_ptr_d = rpl_ptr_q + IDX_W'(1);
            end
          end
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          flush_pend_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      valid_d = '0;
      if (state_q inside {S_PTW_REQ, S_PTW_WAIT}) flush_pend_d = 1'b1;
    end
    if (fill_en) valid_d[fill_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      vaddr_q      <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
      rpl_ptr_q    <= '0;
      valid_q      <= '0;
      resp_paddr_q <= '0;
      resp_fault_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      ptw_vaddr_q  <= '0;
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
      rpl_ptr_q    <= rpl_ptr_d;
      valid_q      <= valid_d;
      resp_paddr_q <= resp_paddr_d;
      resp_fault_q <= resp_fault_d;
      resp_hit_q   <= resp_hit_d;
      ptw_vaddr_q  <= ptw_vaddr_d;
    end
  end

  // NOTE: entry payload is deliberately not reset; valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      vpn_q[fill_idx]   <= vaddr_q[31:12];
      ppn_q[fill_idx]   <= ptw_pte_i[31:12];
      flags_q[fill_idx] <= ptw_pte_i[3:0];
    end
  end

  assign req_ready_o      = rst && (state_q == S_IDLE) && !flush_i;
  assign resp_valid_o     = (state_q == S_RESP);
  assign ptw_req_valid_o  = (state_q == S_PTW_REQ);
  assign ptw_resp_ready_o = (state_q == S_PTW_WAIT);
  assign resp_paddr_o     = resp_paddr_q;
  assign resp_fault_o     = resp_fault_q;
  assign resp_hit_o       = resp_hit_q;
  assign ptw_vaddr_o      = ptw_vaddr_q;

endmodule

// File: tb/tb_tlb.sv
// Bench for tlb: directed scenarios plus a randomized run scored against an
// entry-table reference model with lowest-free / round-robin refill.
module tb_tlb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i = '0;
  logic [1:0]  req_acc_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_paddr_o;
  logic        resp_fault_o;
  logic        resp_hit_o;
  logic        flush_i = 1'b0;
  logic        ptw_req_valid_o;
  logic        ptw_req_ready_i = 1'b0;
  logic [31:0] ptw_vaddr_o;
  logic        ptw_resp_valid_i = 1'b0;
  logic        ptw_resp_ready_o;
  logic [31:0] ptw_pte_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the most recent run_access.
  int          r_walks, r_lat, r_ptw_lat;
  logic [31:0] r_walk_va, r_paddr;
  logic        r_fault, r_hit;
  bit          r_unstable, r_timeout;

  // Reference model state.
  bit          m_valid [8];
  logic [19:0] m_vpn   [8];
  logic [31:0] m_pte   [8];
  int          m_ptr;

  tlb #(.ENTRIES(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_vaddr_i      (req_vaddr_i),
    .req_acc_i        (req_acc_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_paddr_o     (resp_paddr_o),
    .resp_fault_o     (resp_fault_o),
    .resp_hit_o       (resp_hit_o),
    .flush_i          (flush_i),
    .ptw_req_valid_o  (ptw_req_valid_o),
    .ptw_req_ready_i  (ptw_req_ready_i),
    .ptw_vaddr_o      (ptw_vaddr_o),
    .ptw_resp_valid_i (ptw_resp_valid_i),
    .ptw_resp_ready_o (ptw_resp_ready_o),
    .ptw_pte_i        (ptw_pte_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // One complete translation, acting as requester and ptw. Stall counts hold the
  // corresponding ready low for that many cycles after the valid appears.
  task automatic run_access(input logic [31:0] va, input logic [1:0] acc, input logic [31:0] pte,
                            input int ptw_stall, input int rsp_stall, input bit flush_in_wait);
    int cyc, pstall, rstall;
    bit done, flushed;
    r_walks = 0; r_walk_va = '0; r_paddr = '0; r_fault = 1'b0; r_hit = 1'b0;
    r_lat = -1; r_ptw_lat = -1; r_unstable = 1'b0; r_timeout = 1'b0;
    @(posedge clk); #1;
    cyc = 0;
    while (!req_ready_o && cyc < 50) begin @(posedge clk); #1; cyc++; end
    req_valid_i = 1'b1; req_vaddr_i = va; req_acc_i = acc;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_vaddr_i = $urandom; req_acc_i = 2'($urandom);
    cyc = 0; pstall = 0; rstall = 0; done = 1'b0; flushed = 1'b0;
    while (!done && cyc < 200) begin
      ptw_req_ready_i = 1'b0; ptw_resp_valid_i = 1'b0; ptw_pte_i = '0; resp_ready_i = 1'b0; flush_i = 1'b0;
      if (ptw_req_valid_o) begin
        if (r_ptw_lat < 0) begin r_walk_va = ptw_vaddr_o; r_ptw_lat = cyc; end
        else if (ptw_vaddr_o !== r_walk_va) r_unstable = 1'b1;
        if (pstall >= ptw_stall) begin ptw_req_ready_i = 1'b1; r_walks++; end
        else pstall++;
      end
      if (ptw_resp_ready_o) begin
        if (flush_in_wait && !flushed) begin flush_i = 1'b1; flushed = 1'b1; end
        else begin ptw_resp_valid_i = 1'b1; ptw_pte_i = pte; end
      end
      if (resp_valid_o) begin
        if (r_lat < 0) begin r_lat = cyc; r_paddr = resp_paddr_o; r_fault = resp_fault_o; r_hit = resp_hit_o; end
        else if ({resp_paddr_o, resp_fault_o, resp_hit_o} !== {r_paddr, r_fault, r_hit}) r_unstable = 1'b1;
        if (rstall >= rsp_stall) begin resp_ready_i = 1'b1; done = 1'b1; end
        else rstall++;
      end
      @(posedge clk); #1; cyc++;
    end
    ptw_req_ready_i = 1'b0; ptw_resp_valid_i = 1'b0; resp_ready_i = 1'b0; flush_i = 1'b0;
    r_timeout = !done;
  endtask

  // One-cycle flush in IDLE with a competing request; returns req_ready_o seen during it.
  task automatic do_idle_flush(output logic rdy);
    @(posedge clk); #1;
    flush_i = 1'b1; req_valid_i = 1'b1; req_vaddr_i = 32'h0; req_acc_i = 2'd0;
    #1 rdy = req_ready_o;
    @(posedge clk); #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic model_access(input logic [31:0] va, input logic [1:0] acc, input logic [31:0] walk_pte,
                              input bit fw, output int e_walks, output logic [31:0] e_paddr,
                              output logic e_fault, output logic e_hit);
    int hit_idx, tgt;
    logic [31:0] p;
    logic allowed;
    hit_idx = -1;
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_vpn[i] == va[31:12]) hit_idx = i;
    if (hit_idx >= 0) begin
      p = m_pte[hit_idx]; e_hit = 1'b1; e_walks = 0;
    end else begin
      p = walk_pte; e_hit = 1'b0; e_walks = 1;
      if (fw) begin
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      end else if (p[0]) begin
        tgt = -1;
        for (int i = 7; i >= 0; i--) if (!m_valid[i]) tgt = i;
        if (tgt < 0) begin tgt = m_ptr; m_ptr = (m_ptr + 1) % 8; end
        m_valid[tgt] = 1'b1; m_vpn[tgt] = va[31:12]; m_pte[tgt] = p;
      end
    end
    case (acc)
      2'd1:    allowed = p[2];
      2'd2:    allowed = p[3];
      default: allowed = p[1];
    endcase
    e_fault = !p[0] || !allowed;
    e_paddr = e_fault ? 32'h0 : {p[31:12], va[11:0]};
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({req_ready_o, resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o, resp_fault_o, resp_hit_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/rv/pv/pr/flt/hit=%b expected 000000",
               {req_ready_o, resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o, resp_fault_o, resp_hit_o});
    end
    n_tests++;
    if ({resp_paddr_o, ptw_vaddr_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got paddr=%h ptw_vaddr=%h expected 0", resp_paddr_o, ptw_vaddr_o);
    end
    @(posedge clk); #1; rst = 1'b1; #1;
    n_tests++;
    if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
  endtask

  task automatic test_basic_walk();
    run_access(32'h00001234, 2'd0, 32'h1100000F, 0, 0, 1'b0);
    n_tests++;
    if (r_timeout || r_walks != 1 || r_walk_va !== 32'h00001234) begin
      n_fail++; $display("FAIL basic_walk: got timeout=%0b walks=%0d va=%h expected walks=1 va=00001234", r_timeout, r_walks, r_walk_va);
    end
    n_tests++;
    if ({r_paddr, r_fault, r_hit} !== {32'h11000234, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL basic_resp: got paddr=%h fault=%b hit=%b expected 11000234/0/0", r_paddr, r_fault, r_hit);
    end
    n_tests++;
    if (r_ptw_lat != 1 || r_lat != 3) begin
      n_fail++; $display("FAIL miss_latency: got ptw=%0d resp=%0d expected ptw=1 resp=3", r_ptw_lat, r_lat);
    end
    run_access(32'h00001234, 2'd0, 32'h0, 0, 0, 1'b0);
    n_tests++;
    if (r_timeout || r_walks != 0 || r_ptw_lat >= 0) begin
      n_fail++; $display("FAIL hit_no_walk: got timeout=%0b walks=%0d expected walks=0", r_timeout, r_walks);
    end
    n_tests++;
    if ({r_paddr, r_fault, r_hit} !== {32'h11000234, 1'b0, 1'b1} || r_lat != 1) begin
      n_fail++; $display("FAIL hit_resp: got paddr=%h fault=%b hit=%b lat=%0d expected 11000234/0/1 lat=1", r_paddr, r_fault, r_hit, r_lat);
    end
  endtask

  task automatic test_invalid_pte();
    for (int k = 0; k < 2; k++) begin
      run_access(32'h80000000, 2'd0, 32'h00000000, 0, 0, 1'b0);
      n_tests++;
      if (r_timeout || r_walks != 1 || {r_paddr, r_fault, r_hit} !== {32'h0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL invalid_pte_%0d: got walks=%0d paddr=%h fault=%b hit=%b expected walks=1 0/1/0", k, r_walks, r_paddr, r_fault, r_hit);
      end
    end
  endtask

  task automatic test_permission();
    run_access(32'h00002010, 2'd2, 32'h12000007, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 1 || {r_paddr, r_fault, r_hit} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL exec_walk: got walks=%0d paddr=%h fault=%b hit=%b expected walks=1 0/1/0", r_walks, r_paddr, r_fault, r_hit);
    end
    run_access(32'h00002010, 2'd2, 32'h0, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 0 || {r_paddr, r_fault, r_hit} !== {32'h0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL exec_hit: got walks=%0d paddr=%h fault=%b hit=%b expected walks=0 0/1/1", r_walks, r_paddr, r_fault, r_hit);
    end
    run_access(32'h00002010, 2'd1, 32'h0, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 0 || {r_paddr, r_fault, r_hit} !== {32'h12000010, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL write_hit: got walks=%0d paddr=%h fault=%b hit=%b expected walks=0 12000010/0/1", r_walks, r_paddr, r_fault, r_hit);
    end
  endtask

  task automatic test_eviction();
    logic rdy;
    int misses;
    do_idle_flush(rdy);
    n_tests++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_ready: got %b expected 0", rdy); end
    misses = 0;
    for (int p = 0; p < 8; p++) begin
      run_access(32'(p) << 12, 2'd0, ((32'h20000 + 32'(p)) << 12) | 32'hF, 0, 0, 1'b0);
      misses += r_walks;
    end
    n_tests++;
    if (misses != 8) begin n_fail++; $display("FAIL fill_misses: got %0d expected 8", misses); end
    run_access(32'h00000000, 2'd0, 32'h0, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 0 || r_paddr !== 32'h20000000) begin
      n_fail++; $display("FAIL page0_before_evict: got walks=%0d paddr=%h expected 0/20000000", r_walks, r_paddr);
    end
    run_access(32'h00008000, 2'd0, 32'h2000800F, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 1 || r_paddr !== 32'h20008000) begin
      n_fail++; $display("FAIL evict_refill: got walks=%0d paddr=%h expected 1/20008000", r_walks, r_paddr);
    end
    run_access(32'h00001abc, 2'd0, 32'h0, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 0 || {r_paddr, r_hit} !== {32'h20001abc, 1'b1}) begin
      n_fail++; $display("FAIL page1_kept: got walks=%0d paddr=%h hit=%b expected 0/20001abc/1", r_walks, r_paddr, r_hit);
    end
    run_access(32'h00000000, 2'd0, 32'h2000000F, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 1 || r_hit !== 1'b0) begin
      n_fail++; $display("FAIL page0_evicted: got walks=%0d hit=%b expected 1/0", r_walks, r_hit);
    end
  endtask

  task automatic test_flush_during_walk();
    logic rdy;
    do_idle_flush(rdy);
    run_access(32'h00003000, 2'd0, 32'h1300000F, 0, 0, 1'b0);
    run_access(32'h00000000, 2'd0, 32'h1000000F, 0, 0, 1'b1);
    n_tests++;
    if (r_timeout || r_walks != 1 || {r_paddr, r_fault, r_hit} !== {32'h10000000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL flush_walk_resp: got walks=%0d paddr=%h fault=%b hit=%b expected 1 10000000/0/0", r_walks, r_paddr, r_fault, r_hit);
    end
    run_access(32'h00000000, 2'd0, 32'h1000000F, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 1) begin n_fail++; $display("FAIL flush_not_installed: got walks=%0d expected 1", r_walks); end
    run_access(32'h00003000, 2'd0, 32'h1300000F, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 1) begin n_fail++; $display("FAIL flush_cleared_old: got walks=%0d expected 1", r_walks); end
  endtask

  task automatic test_stall();
    run_access(32'h00005000, 2'd1, 32'h1500000F, 5, 3, 1'b0);
    n_tests++;
    if (r_timeout || r_unstable) begin
      n_fail++; $display("FAIL stall_stable: got timeout=%0b unstable=%0b expected 0/0", r_timeout, r_unstable);
    end
    n_tests++;
    if (r_walks != 1 || r_walk_va !== 32'h00005000 || r_paddr !== 32'h15000000 || r_fault !== 1'b0 || r_lat != 8) begin
      n_fail++; $display("FAIL stall_resp: got walks=%0d va=%h paddr=%h fault=%b lat=%0d expected 1/00005000/15000000/0/8", r_walks, r_walk_va, r_paddr, r_fault, r_lat);
    end
  endtask

  task automatic test_reset_mid_walk();
    int cyc;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_vaddr_i = 32'h00006000; req_acc_i = 2'd0;
    @(posedge clk); #1; req_valid_i = 1'b0;
    cyc = 0;
    while (!ptw_req_valid_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
    ptw_req_ready_i = 1'b1;
    @(posedge clk); #1; ptw_req_ready_i = 1'b0;
    n_tests++;
    if (ptw_resp_ready_o !== 1'b1) begin n_fail++; $display("FAIL midwalk_wait: got ptw_resp_ready=%b expected 1", ptw_resp_ready_o); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({req_ready_o, resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o, resp_fault_o, resp_hit_o} !== 6'b0 ||
        {resp_paddr_o, ptw_vaddr_o} !== 64'h0) begin
      n_fail++;
      $display("FAIL midwalk_reset: got ctrl=%b paddr=%h ptw_vaddr=%h expected all 0",
               {req_ready_o, resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o, resp_fault_o, resp_hit_o}, resp_paddr_o, ptw_vaddr_o);
    end
    @(posedge clk); #1; rst = 1'b1;
    run_access(32'h00006000, 2'd0, 32'h1600000F, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 1 || r_paddr !== 32'h16000000) begin
      n_fail++; $display("FAIL after_reset_walk: got walks=%0d paddr=%h expected 1/16000000", r_walks, r_paddr);
    end
    run_access(32'h00005000, 2'd0, 32'h1500000F, 0, 0, 1'b0);
    n_tests++;
    if (r_walks != 1) begin n_fail++; $display("FAIL after_reset_cleared: got walks=%0d expected 1", r_walks); end
  endtask

  task automatic test_random();
    logic [19:0] pages [12];
    logic [31:0] pte_tbl [12];
    logic [31:0] va, e_paddr;
    logic [1:0]  acc;
    logic        e_fault, e_hit, rdy;
    int          k, e_walks;
    bit          fw;
    apply_reset();
    model_reset();
    for (int i = 0; i < 12; i++) begin
      pages[i] = {4'(i), 16'($urandom)};
      if ($urandom_range(0, 5) == 0) pte_tbl[i] = 32'h0;
      else pte_tbl[i] = {20'($urandom), 8'h00, 3'($urandom), 1'b1};
    end
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_idle_flush(rdy);
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        n_tests++;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL rand_flush_ready[%0d]: got %b expected 0", n, rdy); end
      end
      k   = $urandom_range(0, 11);
      va  = {pages[k], 12'($urandom)};
      acc = 2'($urandom);
      fw  = ($urandom_range(0, 9) == 0);
      model_access(va, acc, pte_tbl[k], fw, e_walks, e_paddr, e_fault, e_hit);
      run_access(va, acc, pte_tbl[k], $urandom_range(0, 3), $urandom_range(0, 3), fw);
      n_tests++;
      if (r_timeout || r_walks != e_walks || r_unstable) begin
        n_fail++; $display("FAIL rand_walks[%0d]: got timeout=%0b walks=%0d unstable=%0b expected walks=%0d", n, r_timeout, r_walks, r_unstable, e_walks);
      end
      n_tests++;
      if ({r_paddr, r_fault, r_hit} !== {e_paddr, e_fault, e_hit}) begin
        n_fail++; $display("FAIL rand_resp[%0d]: va=%h acc=%0d got %h/%b/%b expected %h/%b/%b", n, va, acc, r_paddr, r_fault, r_hit, e_paddr, e_fault, e_hit);
      end
      if (e_walks == 1) begin
        n_tests++;
        if (r_walk_va !== va) begin n_fail++; $display("FAIL rand_walk_va[%0d]: got %h expected %h", n, r_walk_va, va); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_walk();
    test_invalid_pte();
    test_permission();
    test_eviction();
    test_flush_during_walk();
    test_stall();
    test_reset_mid_walk();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
